argmax_classifier_fix: RTL and testbench

- Downstream of the fixed-point ReLU datapath. Consumes its NUM_CLASSES signed class scores and reports the winning digit index, the winning score, and the margin over the runner-up.
- Snapshots the score vector on a start pulse, then scans it serially with one comparator, one class per cycle.
- Holds the result under a valid/ack handshake so the top-level controller can reuse the datapath while the result is pending.

---
 rtl/argmax_classifier_fix.sv | 109 ++++++++++
 tb/tb_argmax_classifier_fix.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/argmax_classifier_fix.sv
// Serial argmax over a snapshot of signed class scores: winning index, winning score,
// and margin over the runner-up, held under a valid/ack handshake.
module argmax_classifier_fix #(
    parameter int WIDTH         = 8,
    parameter int NUM_CLASSES   = 10,
    parameter int IDX_WIDTH     = 4,
    parameter int MARGIN_THRESH = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic signed [WIDTH-1:0]     scores [NUM_CLASSES-1:0],
    input  logic                        res_ack,
    output logic                        busy,
    output logic                        res_valid,
    output logic        [IDX_WIDTH-1:0] class_idx,
    output logic signed [WIDTH-1:0]     max_val,
    output logic        [WIDTH:0]       margin,
    output logic                        low_conf
);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    localparam logic [IDX_WIDTH-1:0]  LAST     = IDX_WIDTH'(NUM_CLASSES - 1);
    localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH:0]        THRESH   = (WIDTH+1)'(MARGIN_THRESH);

    state_t                     state, state_nxt;
    logic        [IDX_WIDTH-1:0] cnt;
    logic signed [WIDTH-1:0]     snap [NUM_CLASSES-1:0];
    logic signed [WIDTH-1:0]     best_val, second_val, v;
    logic signed [WIDTH-1:0]     best_val_nxt, second_val_nxt;
    logic        [IDX_WIDTH-1:0] best_idx, best_idx_nxt;
    logic        [WIDTH:0]       margin_nxt;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)       state_nxt = SCAN;
            SCAN:    if (cnt == LAST) state_nxt = DONE;
            DONE:    if (res_ack)     state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Strict compare keeps the lowest index on ties; an equal value only lifts the runner-up.
    always_comb begin
        v              = snap[cnt];
        best_val_nxt   = best_val;
        best_idx_nxt   = best_idx;
        second_val_nxt = second_val;
        if (v > best_val) begin
            second_val_nxt = best_val;
            best_val_nxt   = v;
            best_idx_nxt   = cnt;
        end else if (v > second_val) begin
            second_val_nxt = v;
        end
        margin_nxt = {best_val_nxt[WIDTH-1], best_val_nxt} - {second_val_nxt[WIDTH-1], second_val_nxt};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            best_val   <= '0;
            best_idx   <= '0;
            second_val <= '0;
            busy       <= 1'b0;
            res_valid  <= 1'b0;
            class_idx  <= '0;
            max_val    <= '0;
            margin     <= '0;
            low_conf   <= 1'b0;
            for (int i = 0; i < NUM_CLASSES; i++) snap[i] <= '0;
        end else begin
            busy      <= (state_nxt != IDLE);
            res_valid <= (state_nxt == DONE);
            case (state)
                IDLE: if (start) begin
                    snap       <= scores;
                    best_val   <= scores[0];
                    best_idx   <= '0;
                    second_val <= MOST_NEG;
                    cnt        <= IDX_WIDTH'(1);
                end
                SCAN: begin
                    best_val   <= best_val_nxt;
                    best_idx   <= best_idx_nxt;
                    second_val <= second_val_nxt;
                    if (cnt == LAST) begin
                        class_idx <= best_idx_nxt;
                        max_val   <= best_val_nxt;
                        margin    <= margin_nxt;
                        low_conf  <= (margin_nxt <= THRESH);
                    end else begin
                        cnt <= cnt + IDX_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_classifier_fix.sv
// Directed plus randomized checks of argmax_classifier_fix against a queue-based reference.
module tb_argmax_classifier_fix;

    logic clk = 1'b0;
    logic rst, start, res_ack;
    logic signed [7:0] scores [9:0];
    logic signed [7:0] vec    [9:0];
    logic busy, res_valid, low_conf;
    logic [3:0] class_idx;
    logic signed [7:0] max_val;
    logic [8:0] margin;
    logic busy1, res_valid1, low_conf1;
    logic [3:0] class_idx1;
    logic signed [7:0] max_val1;
    logic [8:0] margin1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    argmax_classifier_fix #(.WIDTH(8), .NUM_CLASSES(10), .IDX_WIDTH(4), .MARGIN_THRESH(0)) dut (
        .clk(clk), .rst(rst), .start(start), .scores(scores), .res_ack(res_ack),
        .busy(busy), .res_valid(res_valid), .class_idx(class_idx), .max_val(max_val),
        .margin(margin), .low_conf(low_conf));

    argmax_classifier_fix #(.WIDTH(8), .NUM_CLASSES(10), .IDX_WIDTH(4), .MARGIN_THRESH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .scores(scores), .res_ack(res_ack),
        .busy(busy1), .res_valid(res_valid1), .class_idx(class_idx1), .max_val(max_val1),
        .margin(margin1), .low_conf(low_conf1));

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: first maximum wins; runner-up is the maximum of everything else.
    function automatic void model(input logic signed [7:0] v [9:0], output int idx, output int mx, output int mg);
        int q[$];
        int sec;
        for (int i = 0; i < 10; i++) q.push_back(int'(v[i]));
        idx = 0;
        for (int i = 1; i < 10; i++) if (q[i] > q[idx]) idx = i;
        mx = q[idx];
        q.delete(idx);
        sec = q[0];
        foreach (q[i]) if (q[i] > sec) sec = q[i];
        mg = mx - sec;
    endfunction

    task automatic pulse_start();
        @(negedge clk);
        scores = vec;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Called right after pulse_start: already one cycle past the start edge.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!res_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!res_valid) lat = 99;
    endtask

    task automatic check_result(input string tag);
        int idx, mx, mg;
        model(vec, idx, mx, mg);
        chk({tag, ".idx"},    class_idx, idx);
        chk({tag, ".max"},    max_val,   mx);
        chk({tag, ".margin"}, margin,    mg);
        chk({tag, ".lc0"},    low_conf,  (mg <= 0) ? 1 : 0);
        chk({tag, ".lc1"},    low_conf1, (mg <= 1) ? 1 : 0);
        chk({tag, ".idx1"},   class_idx1, idx);
    endtask

    task automatic ack();
        res_ack = 1'b1;
        @(negedge clk);
        res_ack = 1'b0;
    endtask

    task automatic full_run(input string tag);
        int lat;
        pulse_start();
        wait_valid(lat);
        chk({tag, ".lat"}, lat, 10);
        check_result(tag);
        ack();
        chk({tag, ".rel"}, res_valid, 0);
    endtask

    initial begin
        int lat, seen;
        logic signed [7:0] vb [9:0];
        rst = 1'b1; start = 1'b0; res_ack = 1'b0;
        for (int i = 0; i < 10; i++) begin scores[i] = 8'sd0; vec[i] = 8'sd0; end
        repeat (3) @(negedge clk);
        chk("rst.busy", busy, 0);       chk("rst.valid", res_valid, 0);
        chk("rst.idx", class_idx, 0);   chk("rst.max", max_val, 0);
        chk("rst.margin", margin, 0);   chk("rst.lc", low_conf, 0);
        chk("rst.lc1", low_conf1, 0);
        rst = 1'b0;

        // Distinct scores, hold without ack, then release
        vec = '{8'sd8, 8'sd2, 8'sd1, 8'sd41, 8'sd5, 8'sd42, 8'sd0, 8'sd9, 8'sd17, 8'sd3};
        pulse_start();
        chk("dist.busy", busy, 1);
        wait_valid(lat);
        chk("dist.lat", lat, 10);
        check_result("dist");
        chk("dist.idx4", class_idx, 4);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("hold.valid", res_valid, 1);
            chk("hold.idx", class_idx, 4);
            chk("hold.max", max_val, 42);
        end
        ack();
        chk("ack.valid", res_valid, 0);
        chk("ack.busy", busy, 0);
        chk("ack.idx_kept", class_idx, 4);
        chk("ack.margin_kept", margin, 1);

        vec = '{8'sd0, 8'sd0, 8'sd30, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd30, 8'sd0, 8'sd0};
        full_run("tie");
        chk("tie.idx2", class_idx, 2);
        for (int i = 0; i < 10; i++) vec[i] = 8'sd0;
        full_run("zero");
        for (int i = 0; i < 10; i++) vec[i] = -8'sd128;
        vec[9] = -8'sd1;
        full_run("neg");
        chk("neg.margin127", margin, 127);

        // Snapshot isolation and start ignored while busy
        vec = '{8'sd1, 8'sd2, 8'sd3, 8'sd99, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8, 8'sd9};
        vb  = '{8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd0, 8'sd120, 8'sd0};
        pulse_start();
        scores = vb;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 3;
        while (!res_valid && lat < 40) begin @(negedge clk); lat++; end
        if (!res_valid) lat = 99;
        chk("snap.lat", lat, 10);
        check_result("snap");
        chk("snap.idx6", class_idx, 6);
        ack();
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (res_valid || busy) seen++;
        end
        chk("snap.no_second", seen, 0);

        // Start coincident with ack is dropped
        vec = vb;
        pulse_start();
        wait_valid(lat);
        chk("coinc.lat", lat, 10);
        res_ack = 1'b1; start = 1'b1;
        @(negedge clk);
        res_ack = 1'b0; start = 1'b0;
        chk("coinc.busy", busy, 0);
        chk("coinc.valid", res_valid, 0);
        seen = 0;
        repeat (12) begin @(negedge clk); if (busy || res_valid) seen++; end
        chk("coinc.idle", seen, 0);

        // Reset mid-scan: rst sampled at the edge ending cycle T+4
        vec = '{8'sd5, 8'sd70, 8'sd3, 8'sd2, 8'sd1, 8'sd0, 8'sd9, 8'sd8, 8'sd7, 8'sd6};
        pulse_start();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid.busy", busy, 0);     chk("mid.valid", res_valid, 0);
        chk("mid.idx", class_idx, 0); chk("mid.max", max_val, 0);
        chk("mid.margin", margin, 0); chk("mid.lc", low_conf, 0);
        full_run("after_rst");
        chk("after_rst.idx8", class_idx, 8);

        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < 10; i++)
                vec[i] = (r % 2) ? 8'($signed($urandom_range(0, 6)) - 3) : 8'($urandom_range(0, 255));
            full_run("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
